// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN engine types and dimension helpers
package cnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } conv_state_t;

    function automatic int out_dim(input int in_size, input int k, input int stride, input int pad);
        return (in_size + 2 * pad - k) / stride + 1;
    endfunction

    // Product width plus growth for n_terms products plus the shifted bias.
    function automatic int acc_width(input int dw, input int n_terms);
        return 2 * dw + $clog2(n_terms) + 2;
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pointwise_conv_seq_if.sv
// rtl/pointwise_conv_seq_if.sv - start/done control handshake with run options
interface pointwise_conv_seq_if;
    logic start;
    logic relu_en;
    logic res_en;
    logic busy;
    logic done;

    modport master (output start, output relu_en, output res_en, input busy, input done);
    modport slave  (input start, input relu_en, input res_en, output busy, output done);
endinterface

// File: rtl/conv_postproc.sv
// rtl/conv_postproc.sv - accumulator rescale, residual add, ReLU and saturation
module conv_postproc #(
    parameter int DW        = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 36
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic signed [DW-1:0]    residual,
    input  logic                    res_en,
    input  logic                    relu_en,
    output logic signed [DW-1:0]    result
);
    // One guard bit so the residual add cannot wrap before saturation.
    localparam int SW = ACC_W + 1;
    localparam logic signed [SW-1:0] MAX_V = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [SW-1:0] shifted;
    logic signed [SW-1:0] summed;
    logic signed [SW-1:0] rectified;
    logic signed [SW-1:0] clamped;

    always_comb begin
        shifted   = $signed({acc[ACC_W-1], acc}) >>> FRAC_BITS;
        summed    = res_en ? (shifted + {{(SW-DW){residual[DW-1]}}, residual}) : shifted;
        rectified = (relu_en && summed[SW-1]) ? '0 : summed;
        if (rectified > MAX_V) begin
            clamped = MAX_V;
        end else if (rectified < MIN_V) begin
            clamped = MIN_V;
        end else begin
            clamped = rectified;
        end
        result = clamped[DW-1:0];
    end

endmodule

// File: rtl/pointwise_conv_seq.sv
// rtl/pointwise_conv_seq.sv - sequential 1x1 convolution on one shared MAC
module pointwise_conv_seq
    import cnn_pkg::*;
#(
    parameter int BATCH_SIZE   = 1,
    parameter int IN_CHANNELS  = 4,
    parameter int OUT_CHANNELS = 4,
    parameter int IN_HEIGHT    = 4,
    parameter int IN_WIDTH     = 4,
    parameter int STRIDE       = 1,
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = 8,
    localparam int OH          = out_dim(IN_HEIGHT, 1, STRIDE, 0),
    localparam int OW          = out_dim(IN_WIDTH, 1, STRIDE, 0)
) (
    input  logic clk,
    input  logic rst,
    pointwise_conv_seq_if.slave ctrl,
    input  logic [BATCH_SIZE*IN_CHANNELS*IN_HEIGHT*IN_WIDTH*DATA_WIDTH-1:0] input_tensor_flat,
    input  logic [OUT_CHANNELS*IN_CHANNELS*DATA_WIDTH-1:0]                  weights_flat,
    input  logic [OUT_CHANNELS*DATA_WIDTH-1:0]                              bias_flat,
    input  logic [BATCH_SIZE*OUT_CHANNELS*OH*OW*DATA_WIDTH-1:0]             residual_flat,
    output logic [BATCH_SIZE*OUT_CHANNELS*OH*OW*DATA_WIDTH-1:0]             output_tensor_flat
);
    localparam int DW    = DATA_WIDTH;
    localparam int IC    = IN_CHANNELS;
    localparam int OC    = OUT_CHANNELS;
    localparam int N_IN  = BATCH_SIZE * IC * IN_HEIGHT * IN_WIDTH;
    localparam int N_W   = OC * IC;
    localparam int N_OUT = BATCH_SIZE * OC * OH * OW;
    localparam int ACC_W = acc_width(DW, IC);
    localparam int BW    = idx_width(BATCH_SIZE);
    localparam int OCW   = idx_width(OC);
    localparam int OHW   = idx_width(OH);
    localparam int OWW   = idx_width(OW);
    localparam int ICW   = idx_width(IC);
    localparam int IIW   = idx_width(N_IN);
    localparam int WIW   = idx_width(N_W);
    localparam int OIW   = idx_width(N_OUT);

    logic signed [DW-1:0] in_mem  [N_IN];
    logic signed [DW-1:0] w_mem   [N_W];
    logic signed [DW-1:0] b_mem   [OC];
    logic signed [DW-1:0] r_mem   [N_OUT];
    logic signed [DW-1:0] out_mem [N_OUT];

    for (genvar i = 0; i < N_IN; i++) begin : g_in
        assign in_mem[i] = input_tensor_flat[i*DW +: DW];
    end
    for (genvar i = 0; i < N_W; i++) begin : g_w
        assign w_mem[i] = weights_flat[i*DW +: DW];
    end
    for (genvar i = 0; i < OC; i++) begin : g_b
        assign b_mem[i] = bias_flat[i*DW +: DW];
    end
    for (genvar i = 0; i < N_OUT; i++) begin : g_out
        assign r_mem[i] = residual_flat[i*DW +: DW];
        assign output_tensor_flat[i*DW +: DW] = out_mem[i];
    end

    conv_state_t          state;
    logic                 busy_q;
    logic                 done_q;
    logic                 relu_q;
    logic                 res_q;
    logic [BW-1:0]        b_cnt;
    logic [OCW-1:0]       oc_cnt;
    logic [OHW-1:0]       oh_cnt;
    logic [OWW-1:0]       ow_cnt;
    logic [ICW-1:0]       ic_cnt;
    logic [OIW-1:0]       out_idx;
    logic signed [ACC_W-1:0] acc;

    logic [IIW-1:0]          in_idx;
    logic [WIW-1:0]          w_idx;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [DW-1:0]    pp_result;

    always_comb begin
        in_idx = IIW'(((int'(b_cnt) * IC + int'(ic_cnt)) * IN_HEIGHT + int'(oh_cnt) * STRIDE)
                      * IN_WIDTH + int'(ow_cnt) * STRIDE);
        w_idx    = WIW'(int'(oc_cnt) * IC + int'(ic_cnt));
        prod     = in_mem[in_idx] * w_mem[w_idx];
        prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        bias_ext = {{(ACC_W-DW){b_mem[oc_cnt][DW-1]}}, b_mem[oc_cnt]};
    end

    conv_postproc #(
        .DW        (DW),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
    ) u_postproc (
        .acc      (acc),
        .residual (r_mem[out_idx]),
        .res_en   (res_q),
        .relu_en  (relu_q),
        .result   (pp_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            relu_q  <= 1'b0;
            res_q   <= 1'b0;
            b_cnt   <= '0;
            oc_cnt  <= '0;
            oh_cnt  <= '0;
            ow_cnt  <= '0;
            ic_cnt  <= '0;
            out_idx <= '0;
            acc     <= '0;
            for (int i = 0; i < N_OUT; i++) out_mem[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ctrl.start) begin
                        state   <= ST_INIT;
                        busy_q  <= 1'b1;
                        relu_q  <= ctrl.relu_en;
                        res_q   <= ctrl.res_en;
                        b_cnt   <= '0;
                        oc_cnt  <= '0;
                        oh_cnt  <= '0;
                        ow_cnt  <= '0;
                        out_idx <= '0;
                    end
                end
                ST_INIT: begin
                    acc    <= bias_ext <<< FRAC_BITS;
                    ic_cnt <= '0;
                    state  <= ST_MAC;
                end
                ST_MAC: begin
                    acc <= acc + prod_ext;
                    if (ic_cnt == ICW'(IC - 1)) begin
                        ic_cnt <= '0;
                        state  <= ST_WRITE;
                    end else begin
                        ic_cnt <= ic_cnt + 1'b1;
                    end
                end
                ST_WRITE: begin
                    out_mem[out_idx] <= pp_result;
                    if (out_idx == OIW'(N_OUT - 1)) begin
                        // done and busy change on the edge that stores the last element
                        state   <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        b_cnt   <= '0;
                        oc_cnt  <= '0;
                        oh_cnt  <= '0;
                        ow_cnt  <= '0;
                        out_idx <= '0;
                    end else begin
                        state   <= ST_INIT;
                        out_idx <= out_idx + 1'b1;
                        if (ow_cnt == OWW'(OW - 1)) begin
                            ow_cnt <= '0;
                            if (oh_cnt == OHW'(OH - 1)) begin
                                oh_cnt <= '0;
                                if (oc_cnt == OCW'(OC - 1)) begin
                                    oc_cnt <= '0;
                                    b_cnt  <= b_cnt + 1'b1;
                                end else begin
                                    oc_cnt <= oc_cnt + 1'b1;
                                end
                            end else begin
                                oh_cnt <= oh_cnt + 1'b1;
                            end
                        end else begin
                            ow_cnt <= ow_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ctrl.busy = busy_q;
    assign ctrl.done = done_q;

endmodule

// File: tb/tb_pointwise_conv_seq.sv
// tb/tb_pointwise_conv_seq.sv - directed bench for pointwise_conv_seq
module tb_pointwise_conv_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pointwise_conv_seq_if id_if ();
    pointwise_conv_seq_if st_if ();
    pointwise_conv_seq_if sat_if ();

    logic [255:0]  id_in, id_res, id_out;
    logic [15:0]   id_w, id_b;
    logic [255:0]  st_in;
    logic [15:0]   st_w, st_b;
    logic [63:0]   st_res, st_out;
    logic [1023:0] sat_in, sat_res, sat_out;
    logic [255:0]  sat_w;
    logic [63:0]   sat_b;

    pointwise_conv_seq #(
        .BATCH_SIZE(1), .IN_CHANNELS(1), .OUT_CHANNELS(1), .IN_HEIGHT(4), .IN_WIDTH(4),
        .STRIDE(1), .DATA_WIDTH(16), .FRAC_BITS(8)
    ) u_id (
        .clk(clk), .rst(rst_n), .ctrl(id_if),
        .input_tensor_flat(id_in), .weights_flat(id_w), .bias_flat(id_b),
        .residual_flat(id_res), .output_tensor_flat(id_out)
    );

    pointwise_conv_seq #(
        .BATCH_SIZE(1), .IN_CHANNELS(1), .OUT_CHANNELS(1), .IN_HEIGHT(4), .IN_WIDTH(4),
        .STRIDE(2), .DATA_WIDTH(16), .FRAC_BITS(8)
    ) u_st (
        .clk(clk), .rst(rst_n), .ctrl(st_if),
        .input_tensor_flat(st_in), .weights_flat(st_w), .bias_flat(st_b),
        .residual_flat(st_res), .output_tensor_flat(st_out)
    );

    pointwise_conv_seq #(
        .BATCH_SIZE(1), .IN_CHANNELS(4), .OUT_CHANNELS(4), .IN_HEIGHT(4), .IN_WIDTH(4),
        .STRIDE(1), .DATA_WIDTH(16), .FRAC_BITS(8)
    ) u_sat (
        .clk(clk), .rst(rst_n), .ctrl(sat_if),
        .input_tensor_flat(sat_in), .weights_flat(sat_w), .bias_flat(sat_b),
        .residual_flat(sat_res), .output_tensor_flat(sat_out)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ctrl(input int which, input logic s, input logic relu, input logic res);
        case (which)
            0: begin id_if.start = s; id_if.relu_en = relu; id_if.res_en = res; end
            1: begin st_if.start = s; st_if.relu_en = relu; st_if.res_en = res; end
            default: begin sat_if.start = s; sat_if.relu_en = relu; sat_if.res_en = res; end
        endcase
    endtask

    function automatic logic get_done(input int which);
        case (which)
            0: return id_if.done;
            1: return st_if.done;
            default: return sat_if.done;
        endcase
    endfunction

    function automatic logic get_busy(input int which);
        case (which)
            0: return id_if.busy;
            1: return st_if.busy;
            default: return sat_if.busy;
        endcase
    endfunction

    task automatic wait_done(input int which, output int cyc);
        cyc = 0;
        while (!get_done(which) && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    // Pulses start for one edge, then returns the cycle count from the start edge to done.
    task automatic run(input int which, input logic relu, input logic res, output int cyc);
        set_ctrl(which, 1'b1, relu, res);
        @(posedge clk); #1;
        set_ctrl(which, 1'b0, 1'b0, 1'b0);
        check("busy_after_start", 256'(get_busy(which)), 256'(1));
        wait_done(which, cyc);
        check("busy_at_done", 256'(get_busy(which)), 256'(0));
        @(posedge clk); #1;
        check("done_one_cycle", 256'(get_done(which)), 256'(0));
    endtask

    int cyc;
    logic [255:0] exp_id;

    initial begin
        rst_n = 1'b0;
        set_ctrl(0, 1'b0, 1'b0, 1'b0);
        set_ctrl(1, 1'b0, 1'b0, 1'b0);
        set_ctrl(2, 1'b0, 1'b0, 1'b0);
        id_in = '0; id_res = '0; id_w = '0; id_b = '0;
        st_in = '0; st_res = '0; st_w = '0; st_b = '0;
        sat_in = '0; sat_res = '0; sat_w = '0; sat_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 256'(sat_if.busy), 256'(0));
        check("reset_done", 256'(sat_if.done), 256'(0));
        check("reset_out", sat_out[255:0] | sat_out[1023:768] | id_out, 256'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // identity: 1x1 weight of 1.0 passes the input through
        for (int k = 0; k < 16; k++) id_in[k*16 +: 16] = 16'(k * 256);
        exp_id = {16'h0F00, 16'h0E00, 16'h0D00, 16'h0C00, 16'h0B00, 16'h0A00, 16'h0900, 16'h0800,
                  16'h0700, 16'h0600, 16'h0500, 16'h0400, 16'h0300, 16'h0200, 16'h0100, 16'h0000};
        id_w = 16'h0100;
        id_b = 16'h0000;
        run(0, 1'b0, 1'b0, cyc);
        check("id_latency", 256'(cyc), 256'(48));
        check("id_out", id_out, exp_id);

        // bias plus a tiny negative product: 0x180<<8 - 1 floors to 0x17F
        id_in = {16{16'h0001}};
        id_w  = 16'hFFFF;
        id_b  = 16'h0180;
        run(0, 1'b0, 1'b0, cyc);
        check("bias_floor", id_out, {16{16'h017F}});

        // residual and ReLU: 2.0 * -1.0 = -2.0, residual +1.0
        id_in  = {16{16'h0200}};
        id_w   = 16'hFF00;
        id_b   = 16'h0000;
        id_res = {16{16'h0100}};
        run(0, 1'b0, 1'b0, cyc);
        check("plain_neg", id_out, {16{16'hFE00}});
        run(0, 1'b0, 1'b1, cyc);
        check("res_add", id_out, {16{16'hFF00}});
        run(0, 1'b1, 1'b1, cyc);
        check("res_relu", id_out, {16{16'h0000}});

        // stride 2 picks rows/cols 0 and 2
        for (int k = 0; k < 16; k++) st_in[k*16 +: 16] = 16'(k * 256);
        st_w = 16'h0100;
        run(1, 1'b0, 1'b0, cyc);
        check("stride_latency", 256'(cyc), 256'(12));
        check("stride_out", 256'(st_out), 256'({16'h0A00, 16'h0800, 16'h0200, 16'h0000}));

        // saturation, positive and negative
        sat_in = {64{16'h7FFF}};
        sat_w  = {16{16'h7FFF}};
        run(2, 1'b0, 1'b0, cyc);
        check("sat_latency", 256'(cyc), 256'(384));
        check("sat_pos_q0", sat_out[255:0],    {16{16'h7FFF}});
        check("sat_pos_q3", sat_out[1023:768], {16{16'h7FFF}});
        sat_in = {64{16'h8001}};
        run(2, 1'b0, 1'b0, cyc);
        check("sat_neg_q0", sat_out[255:0],    {16{16'h8000}});
        check("sat_neg_q2", sat_out[767:512],  {16{16'h8000}});

        // reset during the MAC phase of element 5
        sat_in = {64{16'h0100}};
        sat_w  = {16{16'h0100}};
        sat_b  = {4{16'h0100}};
        set_ctrl(2, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        set_ctrl(2, 1'b0, 1'b0, 1'b0);
        repeat (31) @(posedge clk);
        #1;
        check("mid_elem4_written", 256'(sat_out[4*16 +: 16]), 256'(16'h0500));
        check("mid_elem5_kept", 256'(sat_out[5*16 +: 16]), 256'(16'h8000));
        rst_n = 1'b0;
        #1;
        check("abort_busy", 256'(sat_if.busy), 256'(0));
        check("abort_done", 256'(sat_if.done), 256'(0));
        check("abort_out", sat_out[255:0] | sat_out[511:256] | sat_out[767:512] | sat_out[1023:768],
              256'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(2, 1'b0, 1'b0, cyc);
        check("rerun_latency", 256'(cyc), 256'(384));
        check("rerun_q0", sat_out[255:0],    {16{16'h0500}});
        check("rerun_q3", sat_out[1023:768], {16{16'h0500}});

        // start held high: ignored while busy and in DONE, accepted right after
        for (int k = 0; k < 16; k++) id_in[k*16 +: 16] = 16'(k * 256);
        id_w = 16'h0100;
        id_b = 16'h0000;
        set_ctrl(0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        wait_done(0, cyc);
        check("hold_latency1", 256'(cyc), 256'(48));
        @(posedge clk); #1;
        check("hold_done_state_busy", 256'(id_if.busy), 256'(0));
        check("hold_done_state_done", 256'(id_if.done), 256'(0));
        @(posedge clk); #1;
        check("hold_restart_busy", 256'(id_if.busy), 256'(1));
        wait_done(0, cyc);
        set_ctrl(0, 1'b0, 1'b0, 1'b0);
        check("hold_latency2", 256'(cyc), 256'(48));
        check("hold_out", id_out, exp_id);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("hold_idle", 256'(id_if.busy), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
